corr_sched: RTL and testbench
=============================

// Module: corr_sched
// PURPOSE
//  Scheduler/sequencer for the sigma_tile correlation-matrix datapath (NPIPES complex-multiply pipes).
//  Walks the upper triangle (incl. diagonal) of the MUL_NUM x MUL_NUM sample-pair matrix and issues NPIPES pairs/cycle.
//  Gates sample-vector loads and counts INT_LENGTH vectors; drives accumulator RAM rd/wr addresses and write enables.
//  Sits between the MemSplit32 sample loader (upstream) and the multiplier/accumulator pipes (downstream).
// PARAMETERS
//  MUL_NUM      6   samples per vector (CHNUM*TWIDTH)
//  NPIPES       2   parallel multiply/accumulate pipes (lanes)
//  INT_LENGTH   10  vectors accumulated per run, >=1
//  CALC_LATENCY 4   cycles from pair issue to accumulator write, >=2
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 synchronous, active-low reset
//  acc_start_i  in   1                 start run; honoured only in IDLE
//  acc_ready_o  out  1                 1 in IDLE
//  smpl_rdy_o   out  1                 loader may write next vector (WAIT_VEC)
//  smpl_vld_i   in   1                 vector fully loaded; honoured only while smpl_rdy_o=1
//  pair_vld_o   out  NPIPES            per-lane pair valid
//  pair_i_o     out  NPIPES*IDXW       per-lane row index, lane k at [k*IDXW+:IDXW]
//  pair_j_o     out  NPIPES*IDXW       per-lane column index (j>=i)
//  ram_rd_addr_o out AW                accumulator read slot (sync-read RAM)
//  ram_wr_addr_o out AW                accumulator write slot
//  ram_we_o     out  NPIPES            per-lane accumulator write enable
//  acc_first_o  out  1                 write product directly (vector 0), no add
//  calc_fin_o   out  1                 1-cycle pulse: run complete, RAM holds result
// BEHAVIOUR
//  CMUL_NUM=MUL_NUM*(MUL_NUM+1)/2; SLOTS=ceil(CMUL_NUM/NPIPES); IDXW=$clog2(MUL_NUM); AW=$clog2(SLOTS).
//  Pair order p=0..CMUL_NUM-1 is row-major: (0,0),(0,1)..(0,M-1),(1,1)..(M-1,M-1).
//  Slot s, lane k carries p=s*NPIPES+k; p>=CMUL_NUM -> pair_vld_o[k]=0, indices 0.
//  FSM IDLE -> WAIT_VEC (acc_start_i; vec_cnt<=0) -> ISSUE (smpl_vld_i; slot<=0)
//   ISSUE: one slot/cycle; after slot SLOTS-1: vec_cnt==INT_LENGTH-1 ? DRAIN : WAIT_VEC (vec_cnt++).
//   DRAIN: until write delay line empty -> DONE (calc_fin_o=1, 1 cycle) -> IDLE.
//  Delay line CALC_LATENCY deep carries {lane valids, slot, first}; first=(vec_cnt==0).
//   Read tap at stage CALC_LATENCY-1: ram_rd_addr_o=slot. Write tap at stage CALC_LATENCY: ram_we_o=valids,
//   ram_wr_addr_o=slot, acc_first_o=first. Issue at cycle t -> rd addr t+CALC_LATENCY-1, we at t+CALC_LATENCY.
//  Outputs registered; ram_we_o/pair_vld_o never asserted outside ISSUE/drain of issued slots.
//  acc_start_i outside IDLE ignored; smpl_vld_i outside WAIT_VEC ignored (loader must obey smpl_rdy_o).
//  acc_start_i and calc_fin_o same cycle: start ignored (DONE is not IDLE).
//  Reset (rst=0 at clock edge): state IDLE, counters 0, delay line cleared; acc_ready_o=1, all other outputs 0.
//   Mid-run reset drops in-flight writes; RAM contents undefined afterwards.
// CONFIGURATION
//  CORR_SCHED_ABORT_EN defined: adds input abort_i (1) and output aborted_o (1).
//   abort_i=1 in any non-IDLE state -> next cycle IDLE, delay line valids cleared (no further ram_we_o),
//   calc_fin_o not pulsed, aborted_o 1-cycle pulse. abort_i in IDLE ignored; abort beats start/vld same cycle.
//  Undefined: ports absent; run always completes or is cut only by rst.
// STRUCTURE
//  Package sigma_corr_pkg: localparams CMUL_NUM/SLOTS/IDXW/AW functions, typedef enum sched_state_t
//   {IDLE,WAIT_VEC,ISSUE,DRAIN,DONE}, typedef struct pair_t {vld,i,j}, struct wr_tag_t {vld,slot,first}.
//  Sub-module corr_pair_gen: incremental (i,j) triangle walker, NPIPES lanes chained combinationally
//   from registered (i,j), init on load; no divider/lookup table.
// TESTING  (MUL_NUM=6, NPIPES=2, INT_LENGTH=2, CALC_LATENCY=4: CMUL_NUM=21, SLOTS=11)
//  Reset: hold rst=0 3 cycles -> acc_ready_o=1, smpl_rdy_o=0, ram_we_o=0, calc_fin_o=0.
//  Sequence: start, vld -> slot0 (0,0)(0,1); slot1 (0,2)(0,3); slot3 (1,1)(1,2); slot10 lane0 (5,5), lane1 vld=0.
//  Timing: slot0 issued at t -> ram_rd_addr_o=0 at t+3, ram_we_o=2'b11 addr0 acc_first_o=1 at t+4;
//   slot10 write ram_we_o=2'b01 addr10; vector 1 writes acc_first_o=0.
//  Completion: second vector's last slot at t' -> calc_fin_o single pulse at t'+5, acc_ready_o=1 at t'+6.
//  Protocol: acc_start_i during ISSUE and smpl_vld_i during ISSUE ignored -> sequence and vec_cnt unchanged.
//  Reset at slot5 of vector 0 -> next cycle IDLE, no ram_we_o for remaining slots;
//   with CORR_SCHED_ABORT_EN, abort_i at slot5 -> aborted_o pulse, no calc_fin_o, no further ram_we_o.

Source files
------------

// File: rtl/sigma_corr_pkg.sv
// Shared types and size helpers for the sigma_tile correlation scheduler.
// Size functions let each module derive its own widths from MUL_NUM/NPIPES.
package sigma_corr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VEC,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_t;

  function automatic int cmul_num(input int mul_num);
    return mul_num * (mul_num + 1) / 2;
  endfunction

  function automatic int slot_count(input int mul_num, input int npipes);
    return (cmul_num(mul_num) + npipes - 1) / npipes;
  endfunction

  // Never returns zero, so single-entry ranges still get a usable bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/corr_pair_gen.sv
// Upper-triangle (i,j) walker: NPIPES lanes chained combinationally from a
// registered lane-0 position, advancing NPIPES pairs per step.
module corr_pair_gen
  import sigma_corr_pkg::*;
#(
  parameter int MUL_NUM = 6,
  parameter int NPIPES  = 2,
  parameter int IDXW    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   advance,
  output logic [NPIPES-1:0]      vld,
  output logic [NPIPES*IDXW-1:0] i_idx,
  output logic [NPIPES*IDXW-1:0] j_idx
);

  // One extra bit so the walker can sit at row MUL_NUM once the triangle is exhausted.
  localparam int IW = IDXW + 1;
  localparam logic [IW-1:0] ROWS = IW'(MUL_NUM);
  localparam logic [IW-1:0] LAST = IW'(MUL_NUM - 1);

  logic [IW-1:0] base_i, base_j;
  logic [IW-1:0] next_i, next_j;

  always_comb begin
    logic [IW-1:0] ci, cj;
    ci    = base_i;
    cj    = base_j;
    vld   = '0;
    i_idx = '0;
    j_idx = '0;
    for (int k = 0; k < NPIPES; k++) begin
      vld[k] = (ci < ROWS);
      if (ci < ROWS) begin
        i_idx[k*IDXW +: IDXW] = ci[IDXW-1:0];
        j_idx[k*IDXW +: IDXW] = cj[IDXW-1:0];
        if (cj == LAST) begin
          ci = ci + IW'(1);
          cj = ci;
        end else begin
          cj = cj + IW'(1);
        end
      end
    end
    next_i = ci;
    next_j = cj;
  end

  always_ff @(posedge clk) begin
    if (!rst || load) begin
      base_i <= '0;
      base_j <= '0;
    end else if (advance) begin
      base_i <= next_i;
      base_j <= next_j;
    end
  end

endmodule

// File: rtl/corr_sched.sv
// Scheduler for the sigma_tile correlation datapath: issues upper-triangle pairs
// and times accumulator RAM reads/writes. Optional abort via CORR_SCHED_ABORT_EN.
module corr_sched
  import sigma_corr_pkg::*;
#(
  parameter  int MUL_NUM      = 6,
  parameter  int NPIPES       = 2,
  parameter  int INT_LENGTH   = 10,
  parameter  int CALC_LATENCY = 4,
  localparam int SLOTS        = slot_count(MUL_NUM, NPIPES),
  localparam int IDXW         = width_of(MUL_NUM),
  localparam int AW           = width_of(SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   acc_start_i,
  output logic                   acc_ready_o,
  output logic                   smpl_rdy_o,
  input  logic                   smpl_vld_i,
  output logic [NPIPES-1:0]      pair_vld_o,
  output logic [NPIPES*IDXW-1:0] pair_i_o,
  output logic [NPIPES*IDXW-1:0] pair_j_o,
  output logic [AW-1:0]          ram_rd_addr_o,
  output logic [AW-1:0]          ram_wr_addr_o,
  output logic [NPIPES-1:0]      ram_we_o,
  output logic                   acc_first_o,
  output logic                   calc_fin_o
`ifdef CORR_SCHED_ABORT_EN
  ,
  input  logic                   abort_i,
  output logic                   aborted_o
`endif
);

  localparam int VW = width_of(INT_LENGTH);
  localparam logic [AW-1:0] SLOT_LAST = AW'(SLOTS - 1);
  localparam logic [VW-1:0] VEC_LAST  = VW'(INT_LENGTH - 1);

  typedef struct packed {
    logic [NPIPES-1:0]      vld;
    logic [NPIPES*IDXW-1:0] i;
    logic [NPIPES*IDXW-1:0] j;
  } pair_t;

  typedef struct packed {
    logic [NPIPES-1:0] vld;
    logic [AW-1:0]     slot;
    logic              first;
  } wr_tag_t;

  sched_state_t state, next_state;
  logic [AW-1:0] slot;
  logic [VW-1:0] vec_cnt;
  wr_tag_t       dl [CALC_LATENCY];
  pair_t         pair_q;
  pair_t         gen;
  logic          in_flight;
  logic          abort;
  logic          abort_hit;
  logic          issue;

`ifdef CORR_SCHED_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign abort_hit = abort && (state != IDLE);
  assign issue     = (state == ISSUE) && !abort_hit;

  corr_pair_gen #(
    .MUL_NUM (MUL_NUM),
    .NPIPES  (NPIPES),
    .IDXW    (IDXW)
  ) u_pair_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (state != ISSUE),
    .advance (state == ISSUE),
    .vld     (gen.vld),
    .i_idx   (gen.i),
    .j_idx   (gen.j)
  );

  always_comb begin
    in_flight = 1'b0;
    for (int k = 0; k < CALC_LATENCY; k++) begin
      in_flight = in_flight | (|dl[k].vld);
    end
  end

  // Abort overrides every other transition so a same-cycle start/vld is dropped.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (acc_start_i) next_state = WAIT_VEC;
      WAIT_VEC: if (smpl_vld_i) next_state = ISSUE;
      ISSUE:    if (slot == SLOT_LAST) next_state = (vec_cnt == VEC_LAST) ? DRAIN : WAIT_VEC;
      DRAIN:    if (!in_flight) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (abort_hit) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      slot          <= '0;
      vec_cnt       <= '0;
      pair_q        <= '0;
      for (int k = 0; k < CALC_LATENCY; k++) dl[k] <= '0;
      acc_ready_o   <= 1'b1;
      smpl_rdy_o    <= 1'b0;
      calc_fin_o    <= 1'b0;
      ram_rd_addr_o <= '0;
      ram_wr_addr_o <= '0;
      ram_we_o      <= '0;
      acc_first_o   <= 1'b0;
    end else begin
      state       <= next_state;
      acc_ready_o <= (next_state == IDLE);
      smpl_rdy_o  <= (next_state == WAIT_VEC);
      calc_fin_o  <= (next_state == DONE);

      if (state == IDLE && next_state == WAIT_VEC) begin
        vec_cnt <= '0;
      end
      if (state == WAIT_VEC) begin
        slot <= '0;
      end else if (state == ISSUE) begin
        slot <= slot + AW'(1);
        if (slot == SLOT_LAST && next_state == WAIT_VEC) vec_cnt <= vec_cnt + VW'(1);
      end

      pair_q <= issue ? gen : '0;

      // Stage 0 lines up with the pair outputs; the RAM taps are one register further on.
      dl[0].vld   <= issue ? gen.vld : '0;
      dl[0].slot  <= issue ? slot : '0;
      dl[0].first <= issue && (vec_cnt == '0);
      for (int k = 1; k < CALC_LATENCY; k++) dl[k] <= dl[k-1];
      if (abort_hit) begin
        for (int k = 0; k < CALC_LATENCY; k++) dl[k] <= '0;
      end

      ram_rd_addr_o <= dl[CALC_LATENCY-2].slot;
      ram_wr_addr_o <= dl[CALC_LATENCY-1].slot;
      ram_we_o      <= abort_hit ? '0 : dl[CALC_LATENCY-1].vld;
      acc_first_o   <= dl[CALC_LATENCY-1].first && !abort_hit;
    end
  end

`ifdef CORR_SCHED_ABORT_EN
  always_ff @(posedge clk) begin
    if (!rst) aborted_o <= 1'b0;
    else      aborted_o <= abort_hit;
  end
`endif

  assign pair_vld_o = pair_q.vld;
  assign pair_i_o   = pair_q.i;
  assign pair_j_o   = pair_q.j;

endmodule

// File: tb/tb_corr_sched.sv
// Scoreboard bench for corr_sched: triangle-order reference model, randomized
// loader timing and protocol noise, mid-run reset (and abort when enabled).
module tb_corr_sched;

  localparam int MUL_NUM      = 6;
  localparam int NPIPES       = 2;
  localparam int INT_LENGTH   = 2;
  localparam int CALC_LATENCY = 4;
  localparam int CMUL_NUM     = 21;
  localparam int SLOTS        = 11;
  localparam int IDXW         = 3;
  localparam int AW           = 4;
  localparam int CUT_SLOT     = 5;

  typedef struct packed {
    logic [NPIPES-1:0]      vld;
    logic [NPIPES*IDXW-1:0] i;
    logic [NPIPES*IDXW-1:0] j;
  } pairExp_t;

  typedef struct packed {
    logic [NPIPES-1:0] we;
    logic [AW-1:0]     addr;
    logic              first;
  } writeExp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic acc_start_i = 1'b0;
  logic smpl_vld_i = 1'b0;
  logic acc_ready_o, smpl_rdy_o, acc_first_o, calc_fin_o;
  logic [NPIPES-1:0]      pair_vld_o, ram_we_o;
  logic [NPIPES*IDXW-1:0] pair_i_o, pair_j_o;
  logic [AW-1:0]          ram_rd_addr_o, ram_wr_addr_o;
`ifdef CORR_SCHED_ABORT_EN
  logic abort_i = 1'b0;
  logic aborted_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int refI[$];
  int refJ[$];
  pairExp_t  pairQ[$];
  writeExp_t writeQ[$];
  int        finQ[$];
  int        issueCycQ[$];
  int        lastIssueCycle = 0;
  logic [AW-1:0] prevRdAddr = '0;
  bit        expectReadyNext = 1'b0;

  corr_sched #(
    .MUL_NUM      (MUL_NUM),
    .NPIPES       (NPIPES),
    .INT_LENGTH   (INT_LENGTH),
    .CALC_LATENCY (CALC_LATENCY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .acc_start_i   (acc_start_i),
    .acc_ready_o   (acc_ready_o),
    .smpl_rdy_o    (smpl_rdy_o),
    .smpl_vld_i    (smpl_vld_i),
    .pair_vld_o    (pair_vld_o),
    .pair_i_o      (pair_i_o),
    .pair_j_o      (pair_j_o),
    .ram_rd_addr_o (ram_rd_addr_o),
    .ram_wr_addr_o (ram_wr_addr_o),
    .ram_we_o      (ram_we_o),
    .acc_first_o   (acc_first_o),
    .calc_fin_o    (calc_fin_o)
`ifdef CORR_SCHED_ABORT_EN
    ,
    .abort_i       (abort_i),
    .aborted_o     (aborted_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) issueCycQ.delete();
`ifdef CORR_SCHED_ABORT_EN
    if (abort_i) issueCycQ.delete();
`endif
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
  endtask

  // Expected traffic for one vector; slots beyond a cut point never reach the pipes or the RAM.
  task automatic pushVector(input int v, input int lastPair, input int lastWrite);
    for (int s = 0; s < SLOTS; s++) begin
      pairExp_t  pe;
      writeExp_t we;
      pe = '0;
      for (int k = 0; k < NPIPES; k++) begin
        int p;
        p = s * NPIPES + k;
        if (p < CMUL_NUM) begin
          pe.vld[k] = 1'b1;
          pe.i[k*IDXW +: IDXW] = IDXW'(refI[p]);
          pe.j[k*IDXW +: IDXW] = IDXW'(refJ[p]);
        end
      end
      we.we    = pe.vld;
      we.addr  = AW'(s);
      we.first = (v == 0);
      if (s <= lastPair)  pairQ.push_back(pe);
      if (s <= lastWrite) writeQ.push_back(we);
    end
  endtask

  // cutKind: 0 = full run, 1 = reset at CUT_SLOT of vector 0, 2 = abort there.
  task automatic applyStimulus(input int cutKind);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (acc_ready_o) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) timeoutFail("wait_acc_ready");
    acc_start_i = 1'b1;
    @(negedge clk);
    acc_start_i = 1'b0;
    if (cutKind == 0) finQ.push_back(1);

    for (int v = 0; v < INT_LENGTH; v++) begin
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
        if (smpl_rdy_o) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      if (!seen) timeoutFail("wait_smpl_rdy");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (cutKind == 0) pushVector(v, SLOTS - 1, SLOTS - 1);
      else              pushVector(v, CUT_SLOT, CUT_SLOT - CALC_LATENCY);
      smpl_vld_i = 1'b1;
      @(negedge clk);
      smpl_vld_i = 1'b0;

      if (cutKind != 0) begin
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
          if (pair_vld_o != '0) begin seen = 1'b1; break; end
          @(negedge clk);
        end
        if (!seen) timeoutFail("wait_first_pair");
        repeat (CUT_SLOT) @(negedge clk);
        if (cutKind == 1) rst = 1'b0;
`ifdef CORR_SCHED_ABORT_EN
        if (cutKind == 2) abort_i = 1'b1;
`endif
        @(negedge clk);
        rst = 1'b1;
`ifdef CORR_SCHED_ABORT_EN
        abort_i = 1'b0;
        checkOutput("cut_aborted", aborted_o, (cutKind == 2));
`endif
        checkOutput("cut_acc_ready", acc_ready_o, 1);
        checkOutput("cut_ram_we", ram_we_o, 0);
        checkOutput("cut_pair_vld", pair_vld_o, 0);
        checkOutput("cut_calc_fin", calc_fin_o, 0);
        repeat (CALC_LATENCY + 6) @(negedge clk);
        return;
      end

      // Start and vld are illegal here (not IDLE / not WAIT_VEC) and must be ignored.
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (smpl_rdy_o || acc_ready_o) begin seen = 1'b1; break; end
        acc_start_i = 1'($urandom_range(0, 1));
        smpl_vld_i  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      acc_start_i = 1'b0;
      smpl_vld_i  = 1'b0;
      if (!seen) timeoutFail("wait_vector_end");
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents pairs, writes or completion.
  always @(negedge clk) begin
    pairExp_t  pe;
    writeExp_t we;
    if (expectReadyNext) begin
      checkOutput("fin_then_ready", acc_ready_o, 1);
      checkOutput("fin_single_pulse", calc_fin_o, 0);
      expectReadyNext = 1'b0;
    end
    if (pair_vld_o != '0) begin
      if (pairQ.size() == 0) begin
        checkOutput("pair_unexpected", pair_vld_o, 0);
      end else begin
        pe = pairQ.pop_front();
        checkOutput("pair_vld", pair_vld_o, pe.vld);
        checkOutput("pair_i", pair_i_o, pe.i);
        checkOutput("pair_j", pair_j_o, pe.j);
      end
      issueCycQ.push_back(cyc);
      lastIssueCycle = cyc;
    end
    if (ram_we_o != '0) begin
      if (writeQ.size() == 0) begin
        checkOutput("write_unexpected", ram_we_o, 0);
      end else begin
        we = writeQ.pop_front();
        checkOutput("ram_we", ram_we_o, we.we);
        checkOutput("ram_wr_addr", ram_wr_addr_o, we.addr);
        checkOutput("acc_first", acc_first_o, we.first);
        checkOutput("ram_rd_addr_prev", prevRdAddr, we.addr);
      end
      if (issueCycQ.size() == 0) checkOutput("write_no_issue", ram_we_o, 0);
      else checkOutput("write_latency", cyc - issueCycQ.pop_front(), CALC_LATENCY);
    end
    if (calc_fin_o) begin
      if (finQ.size() == 0) begin
        checkOutput("fin_unexpected", calc_fin_o, 0);
      end else begin
        void'(finQ.pop_front());
        checkOutput("fin_latency", cyc - lastIssueCycle, CALC_LATENCY + 1);
      end
      expectReadyNext = 1'b1;
    end
    prevRdAddr = ram_rd_addr_o;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < MUL_NUM; i++)
      for (int j = i; j < MUL_NUM; j++) begin
        refI.push_back(i);
        refJ.push_back(j);
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_acc_ready", acc_ready_o, 1);
    checkOutput("reset_smpl_rdy", smpl_rdy_o, 0);
    checkOutput("reset_ram_we", ram_we_o, 0);
    checkOutput("reset_calc_fin", calc_fin_o, 0);
    checkOutput("reset_pair_vld", pair_vld_o, 0);
    rst = 1'b1;
    @(negedge clk);

    repeat (3) applyStimulus(0);
    applyStimulus(1);
    applyStimulus(0);
`ifdef CORR_SCHED_ABORT_EN
    applyStimulus(2);
    applyStimulus(0);
`endif

    repeat (10) @(negedge clk);
    checkOutput("pairq_drained", pairQ.size(), 0);
    checkOutput("writeq_drained", writeQ.size(), 0);
    checkOutput("finq_drained", finQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
